// File: rtl/int8_dot_seq.sv
// int8_dot_seq: streams N INT8 pairs through one int8_mac_unit, optional CLIP8 pass.
// Optional per-command cycle counter: define INT8_DOT_SEQ_PERF_EN.
module int8_dot_seq #(
    parameter int XLEN  = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             cmd_clip_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [7:0]       op_a_i,
    input  logic [7:0]       op_b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [XLEN-1:0]  res_data_o,
    output logic [3:0]       mac_opcode_o,
    output logic [XLEN-1:0]  mac_rs1_o,
    output logic [XLEN-1:0]  mac_rs2_o,
    output logic [XLEN-1:0]  mac_rd_o,
    input  logic [XLEN-1:0]  mac_result_i,
    input  logic             mac_valid_i,
    output logic [31:0]      perf_cycles_o
);

    localparam logic [3:0] MAC8     = 4'h0;
    localparam logic [3:0] MAC8_ACC = 4'h1;
    localparam logic [3:0] MUL8     = 4'h2;
    localparam logic [3:0] CLIP8    = 4'h3;
    localparam logic [3:0] NOP_OP   = 4'hF;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, CLIP, CLIPW, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              clip_q, clip_d;

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            clip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            clip_q  <= clip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        clip_d  = clip_q;
        unique case (state_q)
            IDLE: if (cmd_valid_i) begin
                len_d  = cmd_len_i;
                clip_d = cmd_clip_i;
                acc_d  = '0;
                cnt_d  = '0;
                if (cmd_len_i != '0) state_d = ISSUE;
                else if (cmd_clip_i) state_d = CLIP;
                else                 state_d = DONE;
            end
            ISSUE: if (op_valid_i) state_d = WAIT;
            WAIT: if (mac_valid_i) begin
                acc_d = mac_result_i;
                cnt_d = cnt_inc;
                if (cnt_inc == len_q) state_d = clip_q ? CLIP : DONE;
                else                  state_d = ISSUE;
            end
            CLIP: state_d = CLIPW;
            CLIPW: if (mac_valid_i) begin
                acc_d   = mac_result_i;
                state_d = DONE;
            end
            DONE: if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o  = (state_q == IDLE);
        op_ready_o   = (state_q == ISSUE);
        res_valid_o  = (state_q == DONE);
        res_data_o   = (state_q == DONE) ? acc_q : '0;
        mac_opcode_o = NOP_OP;
        mac_rs1_o    = '0;
        mac_rs2_o    = '0;
        mac_rd_o     = '0;
        if (state_q == ISSUE && op_valid_i) begin
            mac_opcode_o = MAC8_ACC;
            mac_rs1_o    = {{(XLEN-8){op_a_i[7]}}, op_a_i};
            mac_rs2_o    = {{(XLEN-8){op_b_i[7]}}, op_b_i};
            mac_rd_o     = acc_q;
        end else if (state_q == CLIP) begin
            mac_opcode_o = CLIP8;
            mac_rs1_o    = acc_q;
        end
    end

`ifdef INT8_DOT_SEQ_PERF_EN
    logic [31:0] pcnt_q, pcnt_d, pcnt_inc;
    logic [31:0] perf_q, perf_d;

    // Saturating; the accept cycle itself counts as cycle 1.
    assign pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + 32'd1;

    always_comb begin
        pcnt_d = pcnt_q;
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (cmd_valid_i) pcnt_d = 32'd1;
        end else begin
            pcnt_d = pcnt_inc;
        end
        if (state_q == DONE && res_ready_i) perf_d = pcnt_inc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
            perf_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule
